// File: rtl/mips_irq_pkg.sv
// Shared types and constants for the mips interrupt controller.
package mips_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int DBG_PEND_LSB   = 0;
  localparam int DBG_MASK_LSB   = 8;
  localparam int DBG_ID_LSB     = 16;
  localparam int DBG_STATE_LSB  = 20;
  localparam int DBG_GLB_EN_BIT = 24;

  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

endpackage

// File: rtl/mips_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over up to 8 request bits.
module irq_prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/mips_irq_ctrl.sv
// Edge-triggered interrupt controller with fixed priority and a
// request/ack/eret handshake toward the mips pipeline.
//
// state   | meaning
// IDLE    | waiting for an eligible pending source
// REQ     | int_req asserted, id/vector frozen until int_ack
// SERVICE | handler running, no new requests until eret
module mips_irq_ctrl
  import mips_irq_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_in,
  input  logic             glb_en,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             eret,
  output logic             int_req,
  output logic [2:0]       int_id,
  output logic [31:0]      int_vector,
  output logic             in_service,
  output logic [31:0]      dbg_status
);

  irq_state_t       state, state_nxt;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic             ack_ok;
  logic             load_id;
  logic             win_valid;
  logic [2:0]       win_idx;

  assign rise   = irq_in & ~irq_q;
  assign elig   = glb_en ? (pend & mask) : '0;
  assign ack_ok = (state == REQ) && int_ack;

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_ok && (int_id == 3'(i));
    end
  end

  irq_prio_enc #(.N(N_SRC)) u_prio (
    .req   (elig),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load_id   = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = REQ;
          load_id   = 1'b1;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rise in the same cycle as the ack-clear keeps the bit pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q      <= '0;
      pend       <= '0;
      mask       <= '1;
      int_id     <= 3'd0;
      int_vector <= VEC_BASE;
    end else begin
      irq_q <= irq_in;
      pend  <= (pend & ~clr) | rise;
      if (mask_we) begin
        mask <= mask_wdata;
      end
      if (load_id) begin
        int_id     <= win_idx;
        int_vector <= VEC_BASE + ({29'd0, win_idx} * VEC_STRIDE);
      end
    end
  end

  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);

  always_comb begin
    dbg_status                              = '0;
    dbg_status[DBG_PEND_LSB +: N_SRC]       = pend;
    dbg_status[DBG_MASK_LSB +: N_SRC]       = mask;
    dbg_status[DBG_ID_LSB +: 3]             = int_id;
    dbg_status[DBG_STATE_LSB +: 2]          = state;
    dbg_status[DBG_GLB_EN_BIT]              = glb_en;
  end

endmodule
